// File: rtl/dct_pkg.sv
// Shared definitions for the 8x8 IDCT engine.
// Holds block geometry constants, the FSM state type, the signed Q8 cosine
// word type and the cosine magnitude table for the first quarter wave.
package dct_pkg;

  localparam int unsigned N          = 8;
  localparam int unsigned FRAC_BITS  = 8;
  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned COS_W      = 9;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    OUT   = 2'd3
  } idct_state_t;

  typedef logic signed [COS_W-1:0] cos_q8_t;

  // trunc(128*cos(i*pi/16)) for i = 0..8; all other phases fold onto these.
  function automatic logic [7:0] cos_mag(input logic [3:0] idx);
    logic [7:0] mag;
    case (idx)
      4'd0:    mag = 8'd128;
      4'd1:    mag = 8'd125;
      4'd2:    mag = 8'd118;
      4'd3:    mag = 8'd106;
      4'd4:    mag = 8'd90;
      4'd5:    mag = 8'd71;
      4'd6:    mag = 8'd48;
      4'd7:    mag = 8'd24;
      default: mag = 8'd0;
    endcase
    return mag;
  endfunction

endpackage

// File: rtl/idct_cos_1d_lut.sv
// 1-D signed Q8 IDCT cosine table: c(k,n) = trunc(256*s(k)*cos((2n+1)k*pi/16)).
// Ports:
//   k     - frequency index 0..7
//   n     - spatial index 0..7
//   cos_c - combinational signed 9-bit coefficient
module idct_cos_1d_lut
  import dct_pkg::*;
(
  input  logic [2:0] k,
  input  logic [2:0] n,
  output cos_q8_t    cos_c
);

  logic [4:0] phase;
  logic [3:0] idx;
  logic       neg;
  logic [7:0] mag;

  // Reduce (2n+1)k modulo 32 (one full period in pi/16 steps), then fold
  // into the first quadrant with a sign flag.
  always_comb begin
    phase = 5'(7'({n, 1'b1}) * 7'(k));
    idx   = '0;
    neg   = 1'b0;
    case (phase[4:3])
      2'd0: idx = {1'b0, phase[2:0]};
      2'd1: begin
        idx = 4'(5'd16 - phase);
        neg = 1'b1;
      end
      2'd2: begin
        idx = {1'b0, phase[2:0]};
        neg = 1'b1;
      end
      default: idx = 4'(6'd32 - {1'b0, phase});
    endcase
    mag = cos_mag(idx);
    if (k == 3'd0) begin
      cos_c = cos_q8_t'(90);
    end else if (neg) begin
      cos_c = -$signed({1'b0, mag});
    end else begin
      cos_c = $signed({1'b0, mag});
    end
  end

endmodule

// File: rtl/idct_8x8_engine.sv
// Sequential separable 8x8 inverse DCT on a single shared MAC.
// Loads 64 coefficients (k1-major), runs a row pass into the T buffer,
// then computes each pixel with an 8-cycle column MAC and presents it.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - coefficient handshake, in_data signed COEF_W
//   out_valid/out_ready  - pixel handshake, out_data unsigned 8-bit
//   out_last             - marks pixel 63 of a block
module idct_8x8_engine
  import dct_pkg::*;
#(
  parameter int unsigned COEF_W      = 12,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LEVEL_SHIFT = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  localparam logic signed [ACC_W-1:0] LVL     = ACC_W'(LEVEL_SHIFT);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

  idct_state_t state_q, state_d;

  logic [5:0]              ent_q, ent_d;    // coef index / T entry {k1,n2} / pixel {n1,n2}
  logic [2:0]              step_q, step_d;  // MAC step: k2 in the row pass, k1 in the column pass
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [7:0]              out_data_q, out_data_d;

  logic signed [ACC_W-1:0] coef_mem [BLOCK_SIZE];
  logic signed [ACC_W-1:0] t_mem    [BLOCK_SIZE];
  logic                    coef_we, t_we;

  logic                    in_fire, out_fire, last_step;
  logic [2:0]              lut_n;
  cos_q8_t                 lut_c;
  logic signed [ACC_W-1:0] mac_a, mac_c, mac_sum, shifted, biased;
  logic [7:0]              pixel;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign last_step = (step_q == 3'd7);

  // Row pass: X(k1,step)*c(step,n2). Column pass: c(step,n1)*T(step,n2).
  assign lut_n = (state_q == PASS1) ? ent_q[2:0] : ent_q[5:3];
  assign mac_a = (state_q == PASS1) ? coef_mem[{ent_q[5:3], step_q}]
                                    : t_mem[{step_q, ent_q[2:0]}];
  assign mac_c   = ACC_W'(lut_c);
  assign mac_sum = acc_q + mac_a * mac_c;

  // Arithmetic shift floors toward -inf; then level shift and clamp.
  assign shifted = mac_sum >>> FRAC_BITS;
  assign biased  = shifted + LVL;
  always_comb begin
    if (biased < 0) begin
      pixel = 8'd0;
    end else if (biased > PIX_MAX) begin
      pixel = 8'd255;
    end else begin
      pixel = biased[7:0];
    end
  end

  idct_cos_1d_lut u_lut (
    .k     (step_q),
    .n     (lut_n),
    .cos_c (lut_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:  if (in_fire && ent_q == 6'd63) state_d = PASS1;
      PASS1: if (last_step && ent_q == 6'd63) state_d = PASS2;
      PASS2: if (last_step) state_d = OUT;
      OUT:   if (out_fire) state_d = (ent_q == 6'd63) ? LOAD : PASS2;
      default: state_d = LOAD;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    ent_d       = ent_q;
    step_d      = step_q;
    acc_d       = acc_q;
    in_ready_d  = (state_d == LOAD);
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    coef_we     = 1'b0;
    t_we        = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          coef_we = 1'b1;
          ent_d   = ent_q + 6'd1;
        end
      end
      PASS1: begin
        step_d = step_q + 3'd1;
        if (last_step) begin
          t_we  = 1'b1;
          acc_d = '0;
          ent_d = ent_q + 6'd1;
        end else begin
          acc_d = mac_sum;
        end
      end
      PASS2: begin
        step_d = step_q + 3'd1;
        if (last_step) begin
          acc_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = pixel;
          out_last_d  = (ent_q == 6'd63);
        end else begin
          acc_d = mac_sum;
        end
      end
      OUT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          ent_d       = ent_q + 6'd1;
        end
      end
      default: ;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q       <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ent_q       <= ent_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Coefficient and row-pass buffers; contents need no reset.
  always_ff @(posedge clk) begin
    if (coef_we) coef_mem[ent_q] <= ACC_W'($signed(in_data));
    if (t_we)    t_mem[ent_q]    <= shifted;
  end

endmodule

// File: tb/tb_idct_8x8_engine.sv
// Self-checking bench for idct_8x8_engine against a floating-point-derived
// cosine table and a direct double-sum IDCT model.
module tb_idct_8x8_engine;

  localparam int COEF_W = 12;

  typedef int blk_t[64];

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_last;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cosv[8][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  idct_8x8_engine #(.COEF_W(12), .ACC_W(32), .LEVEL_SHIFT(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  function automatic void build_cos();
    real s;
    for (int k = 0; k < 8; k++) begin
      s = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
      for (int n = 0; n < 8; n++)
        cosv[k][n] = $rtoi(256.0 * s * $cos((2.0 * n + 1.0) * k * 3.141592653589793 / 16.0));
    end
  endfunction

  function automatic void ref_block(input blk_t x, output blk_t p);
    int t[64];
    int s;
    for (int k1 = 0; k1 < 8; k1++)
      for (int n2 = 0; n2 < 8; n2++) begin
        s = 0;
        for (int k2 = 0; k2 < 8; k2++) s += x[k1*8+k2] * cosv[k2][n2];
        t[k1*8+n2] = s >>> 8;
      end
    for (int n1 = 0; n1 < 8; n1++)
      for (int n2 = 0; n2 < 8; n2++) begin
        s = 0;
        for (int k1 = 0; k1 < 8; k1++) s += cosv[k1][n1] * t[k1*8+n2];
        s = (s >>> 8) + 128;
        p[n1*8+n2] = (s < 0) ? 0 : (s > 255) ? 255 : s;
      end
  endfunction

  function automatic void rand_block(output blk_t x);
    for (int i = 0; i < 64; i++)
      x[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 600)) - 300 : 0;
    x[0] = int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // Called at a negedge; returns at the negedge following the last accept.
  task automatic send_block(input blk_t x, input bit keep_valid,
                            output int e_cyc, output bit tmo);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < 64 && guard < 5000) begin
      in_valid = 1'b1;
      in_data  = COEF_W'(x[i]);
      hs = in_ready;
      @(posedge clk);
      if (hs) i++;
      guard++;
      @(negedge clk);
    end
    tmo   = (i < 64);
    e_cyc = cyc;
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  // mode 0: always ready; mode 1: 20-cycle stall on pixel 5, random elsewhere.
  task automatic collect_block(input int mode, output blk_t pix, output int first_cyc,
                               output int last_err, output int stab_err, output int ir_err,
                               output bit ir_after, output bit tmo);
    int count = 0;
    int guard = 0;
    int stall = 0;
    bit rdy;
    bit held = 0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    first_cyc = -1; last_err = 0; stab_err = 0; ir_err = 0;
    for (int i = 0; i < 64; i++) pix[i] = -1;
    while (count < 64 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (in_ready) ir_err++;
      rdy = 1'b1;
      if (mode == 1) begin
        if (count == 5 && out_valid && stall < 20) begin
          rdy = 1'b0;
          stall++;
        end else if (count != 5) begin
          rdy = ($urandom_range(0, 2) != 0);
        end
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (held && (out_data !== pd || out_last !== pl)) stab_err++;
        if (out_last !== (count == 63)) last_err++;
        pd = out_data;
        pl = out_last;
        held = !rdy;
        if (rdy) begin
          pix[count] = int'(out_data);
          count++;
        end
      end else begin
        if (held) stab_err++;
        held = 1'b0;
      end
      out_ready = rdy;
    end
    tmo = (count < 64);
    @(negedge clk);
    ir_after  = in_ready;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_dc_positive();
    blk_t x, p;
    int e, f, le, se, ie, nbad;
    bit ira, t1, t2;
    for (int i = 0; i < 64; i++) x[i] = 0;
    x[0] = 1024;
    send_block(x, 1'b0, e, t1);
    collect_block(0, p, f, le, se, ie, ira, t2);
    total++; if (t1 || t2) begin bad++; $display("FAIL dc_pos_timeout got=%b%b want=00", t1, t2); end
    total++; if (f - e !== 520) begin bad++; $display("FAIL dc_pos_latency got=%0d want=520", f - e); end
    total++; if (le !== 0) begin bad++; $display("FAIL dc_pos_out_last got=%0d_errors want=0", le); end
    nbad = 0;
    for (int i = 0; i < 64; i++) if (p[i] !== 254) nbad++;
    total++; if (nbad !== 0) begin bad++; $display("FAIL dc_pos_pixels got=%0d_wrong p0=%0d want=254", nbad, p[0]); end
    total++; if (ira !== 1'b1) begin bad++; $display("FAIL dc_pos_in_ready_after got=%b want=1", ira); end
  endtask

  task automatic test_dc_levels();
    int dc[4]  = '{-1024, 0, 2047, -2048};
    int exp_[4] = '{1, 128, 255, 0};
    blk_t x, p;
    int e, f, le, se, ie, nbad;
    bit ira, t1, t2;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 64; i++) x[i] = 0;
      x[0] = dc[c];
      send_block(x, 1'b0, e, t1);
      collect_block(0, p, f, le, se, ie, ira, t2);
      nbad = 0;
      for (int i = 0; i < 64; i++) if (p[i] !== exp_[c]) nbad++;
      total++;
      if (nbad !== 0 || t1 || t2) begin
        bad++; $display("FAIL dc_level_%0d got=%0d_wrong p0=%0d want=%0d", dc[c], nbad, p[0], exp_[c]);
      end
    end
  endtask

  task automatic test_ac_single();
    blk_t x, p, r;
    int e, f, le, se, ie;
    bit ira, t1, t2;
    for (int i = 0; i < 64; i++) x[i] = 0;
    x[1] = 256;
    ref_block(x, r);
    send_block(x, 1'b0, e, t1);
    collect_block(0, p, f, le, se, ie, ira, t2);
    total++; if (p[0] !== 171) begin bad++; $display("FAIL ac_col0 got=%0d want=171", p[0]); end
    total++; if (p[7] !== 84) begin bad++; $display("FAIL ac_col7 got=%0d want=84", p[7]); end
    for (int i = 0; i < 64; i++) begin
      total++; if (p[i] !== r[i]) begin bad++; $display("FAIL ac_pixel_%0d got=%0d want=%0d", i, p[i], r[i]); end
    end
  endtask

  task automatic test_random_blocks();
    blk_t x, p, r;
    int e, f, le, se, ie, nbad;
    bit ira, t1, t2;
    for (int b = 0; b < 3; b++) begin
      rand_block(x);
      ref_block(x, r);
      send_block(x, 1'b0, e, t1);
      collect_block(0, p, f, le, se, ie, ira, t2);
      nbad = 0;
      for (int i = 0; i < 64; i++) if (p[i] !== r[i]) nbad++;
      total++;
      if (nbad !== 0 || t1 || t2) begin
        bad++; $display("FAIL random_block_%0d got=%0d_wrong p0=%0d want=%0d", b, nbad, p[0], r[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    blk_t x, p, r;
    int e, f, le, se, ie, nbad;
    bit ira, t1, t2;
    rand_block(x);
    ref_block(x, r);
    send_block(x, 1'b0, e, t1);
    collect_block(1, p, f, le, se, ie, ira, t2);
    nbad = 0;
    for (int i = 0; i < 64; i++) if (p[i] !== r[i]) nbad++;
    total++; if (nbad !== 0 || t1 || t2) begin bad++; $display("FAIL bp_pixels got=%0d_wrong want=0", nbad); end
    total++; if (se !== 0) begin bad++; $display("FAIL bp_stability got=%0d_changes want=0", se); end
    total++; if (ie !== 0) begin bad++; $display("FAIL bp_in_ready_early got=%0d_cycles want=0", ie); end
    total++; if (le !== 0) begin bad++; $display("FAIL bp_out_last got=%0d_errors want=0", le); end
    total++; if (ira !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after got=%b want=1", ira); end
  endtask

  task automatic test_reset_mid();
    blk_t x, p;
    int e, f, le, se, ie, nbad;
    bit ira, t1, t2;
    rand_block(x);
    send_block(x, 1'b0, e, t1);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outputs got=%b%b want=00", out_valid, in_ready);
    end
    @(negedge clk);
    for (int i = 0; i < 64; i++) x[i] = 0;
    x[0] = 1024;
    send_block(x, 1'b0, e, t1);
    collect_block(0, p, f, le, se, ie, ira, t2);
    nbad = 0;
    for (int i = 0; i < 64; i++) if (p[i] !== 254) nbad++;
    total++; if (nbad !== 0 || t1 || t2) begin bad++; $display("FAIL mid_reset_pixels got=%0d_wrong want=0", nbad); end
    total++; if (f - e !== 520) begin bad++; $display("FAIL mid_reset_latency got=%0d want=520", f - e); end
  endtask

  task automatic test_back_to_back();
    blk_t xa, xb, pa, pb, ra, rb;
    int e, f, le, se, ie, nbad;
    bit ira, irb, t1, t2, t3, t4;
    rand_block(xa);
    rand_block(xb);
    ref_block(xa, ra);
    ref_block(xb, rb);
    send_block(xa, 1'b1, e, t1);
    collect_block(0, pa, f, le, se, ie, ira, t2);
    total++; if (ira !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_after got=%b want=1", ira); end
    total++; if (ie !== 0) begin bad++; $display("FAIL b2b_in_ready_early got=%0d want=0", ie); end
    send_block(xb, 1'b1, e, t3);
    collect_block(0, pb, f, le, se, ie, irb, t4);
    in_valid = 1'b0;
    nbad = 0;
    for (int i = 0; i < 64; i++) begin
      if (pa[i] !== ra[i]) nbad++;
      if (pb[i] !== rb[i]) nbad++;
    end
    total++; if (nbad !== 0 || t1 || t2 || t3 || t4) begin bad++; $display("FAIL b2b_pixels got=%0d_wrong want=0", nbad); end
    total++; if (f - e !== 520) begin bad++; $display("FAIL b2b_latency got=%0d want=520", f - e); end
    total++; if (irb !== 1'b1) begin bad++; $display("FAIL b2b_second_in_ready got=%b want=1", irb); end
  endtask

  initial begin
    build_cos();
    test_reset();
    test_dc_positive();
    test_dc_levels();
    test_ac_single();
    test_random_blocks();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
